// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// ---------------
// Bit-serial add sequencer wrapped around an external one-bit full-adder cell.
// Two WIDTH-bit operands are added LSB first, one bit per clock, over WIDTH
// cycles. The block drives the cell's A/B/carry inputs from two operand shift
// registers and a carry flip-flop, and collects the cell's sum output in a
// result shift register.
//
// Optional feature macro: SERADD_SUB_EN
//   When defined, a 'sub' input is added. Subtraction is computed as
//   A + ~B + 1: B is inverted one bit at a time and the carry is preset to 1.
//   In that mode carry_out = 1 means "no borrow".
//   When undefined, the block only adds and there is no 'sub' port.

// Protocol checker: flags handshake and idle-drive violations on the top ports.
module serial_add_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic done,
  input logic fa_a,
  input logic fa_b,
  input logic fa_cin
);

  // busy and done are mutually exclusive phases of one operation
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  // The full-adder inputs are held low whenever no operation is running
  a_fa_quiet_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> (!fa_a && !fa_b && !fa_cin));

  // done is a single-cycle pulse; a back-to-back start goes to RUN, not DONE
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  // Bit counter just wide enough to hold WIDTH
  localparam int CW = $clog2(WIDTH + 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [WIDTH-1:0] res_next_s;
  logic             carry_q_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             last_bit_s;
  logic             carry_init_s;
  logic             b_bit_s;
  logic             fa_a_s;
  logic             fa_b_s;
  logic             fa_cin_s;

`ifdef SERADD_SUB_EN
  logic             sub_q_r;

  // Subtract presets the carry to 1 (the "+1" of two's complement)
  always_comb begin
    carry_init_s = sub;
  end

  // Subtract feeds the inverted B bit into the adder
  always_comb begin
    b_bit_s = b_sr_r[0] ^ sub_q_r;
  end
`else
  // Add-only build: carry always starts clear
  always_comb begin
    carry_init_s = 1'b0;
  end

  // Add-only build: B bit goes straight to the adder
  always_comb begin
    b_bit_s = b_sr_r[0];
  end
`endif

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    last_bit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bit_cnt_r == CNT_LAST) begin
          state_s    = ST_DONE;
          last_bit_s = 1'b1;
        end else begin
          state_s    = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Full-adder drive: live only in RUN, otherwise parked low
  always_comb begin
    fa_a_s   = 1'b0;
    fa_b_s   = 1'b0;
    fa_cin_s = 1'b0;
    if (state_r == ST_RUN) begin
      fa_a_s   = a_sr_r[0];
      fa_b_s   = b_bit_s;
      fa_cin_s = carry_q_r;
    end else begin
      fa_a_s   = 1'b0;
      fa_b_s   = 1'b0;
      fa_cin_s = 1'b0;
    end
  end

  // Result shift register after this cycle's sum bit enters at the MSB
  always_comb begin
    res_next_s = {fa_sum, res_sr_r[WIDTH-1:1]};
  end

  // State register plus registered busy/done flags that track the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand capture, serial shifting, carry and bit counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_r    <= {WIDTH{1'b0}};
      b_sr_r    <= {WIDTH{1'b0}};
      res_sr_r  <= {WIDTH{1'b0}};
      carry_q_r <= 1'b0;
      bit_cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      a_sr_r    <= op_a;
      b_sr_r    <= op_b;
      res_sr_r  <= {WIDTH{1'b0}};
      carry_q_r <= carry_init_s;
      bit_cnt_r <= CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
      res_sr_r  <= res_next_s;
      carry_q_r <= fa_cout;
      bit_cnt_r <= bit_cnt_r + CNT_ONE;
    end else begin
      a_sr_r    <= a_sr_r;
      b_sr_r    <= b_sr_r;
      res_sr_r  <= res_sr_r;
      carry_q_r <= carry_q_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

`ifdef SERADD_SUB_EN
  // Subtract mode is latched with the operands and held for the whole run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q_r <= 1'b0;
    end else if (accept_s) begin
      sub_q_r <= sub;
    end else begin
      sub_q_r <= sub_q_r;
    end
  end
`endif

  // Result and final carry update only on the last bit; held until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
    end else if (last_bit_s) begin
      result_r    <= res_next_s;
      carry_out_r <= fa_cout;
    end else begin
      result_r    <= result_r;
      carry_out_r <= carry_out_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign fa_a      = fa_a_s;
  assign fa_b      = fa_b_s;
  assign fa_cin    = fa_cin_s;

  serial_add_ctrl_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy_r),
    .done   (done_r),
    .fa_a   (fa_a_s),
    .fa_b   (fa_b_s),
    .fa_cin (fa_cin_s)
  );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder
// closing the loop on the fa_* pins. Subtract vectors run only when
// SERADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  int vec_cnt = 0;
  int err_cnt = 0;

  int          n_cyc;
  int          n_busy;
  logic [7:0]  cin_seq;
  int          done_cnt;

  // 10 ns clock
  always #5 clk = ~clk;

  // Behavioural model of the external full-adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one rising edge; returns 1 ns after it
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count negedges until done shows up (bounded); record busy and fa_cin per cycle
  task automatic wait_done(output int n, output int nb, output logic [7:0] cin);
    n   = 0;
    nb  = 0;
    cin = 8'h00;
    while (n < 40) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      if (n < 8) cin[n] = fa_cin;
      n++;
    end
    check_val("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Full operation: latency, busy span, result, carry, one-cycle done, hold
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] exp_res, input logic exp_co,
                        output logic [7:0] cin);
    int n;
    int nb;
    start_op(a, b, s);
    wait_done(n, nb, cin);
    check_val({tag, "_lat"},  n, WIDTH);
    check_val({tag, "_busy"}, nb, WIDTH);
    check_val({tag, "_res"},  {24'd0, result}, {24'd0, exp_res});
    check_val({tag, "_co"},   {31'd0, carry_out}, {31'd0, exp_co});
    @(negedge clk);
    check_val({tag, "_done1"}, {31'd0, done}, 32'd0);
    check_val({tag, "_hold"},  {24'd0, result}, {24'd0, exp_res});
  endtask

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    sub   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",  {31'd0, busy}, 32'd0);
    check_val("rst_done",  {31'd0, done}, 32'd0);
    check_val("rst_res",   {24'd0, result}, 32'd0);
    check_val("rst_co",    {31'd0, carry_out}, 32'd0);
    check_val("rst_fa",    {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain additions
    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, cin_seq);
    check_val("idle_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    run_op("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, cin_seq);
    check_val("ovf_cin_seq", {24'd0, cin_seq}, 32'h0000_00FE);
    run_op("ffff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, cin_seq);
    run_op("msb", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, cin_seq);

    // Start pulsed mid-RUN with other operands must be ignored
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    op_a  = 8'h11;
    op_b  = 8'h22;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n_cyc, n_busy, cin_seq);
    check_val("mid_lat", n_cyc, 5);
    check_val("mid_res", {24'd0, result}, 32'h0000_0096);
    check_val("mid_co",  {31'd0, carry_out}, 32'd0);

    // Back-to-back: start held in the DONE cycle
    op_a  = 8'h01;
    op_b  = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n_cyc, n_busy, cin_seq);
    check_val("b2b_lat",  n_cyc, WIDTH);
    check_val("b2b_busy", n_busy, WIDTH);
    check_val("b2b_res",  {24'd0, result}, 32'h0000_0002);
    @(negedge clk);
    check_val("b2b_done1", {31'd0, done}, 32'd0);

    // Reset during the 4th RUN cycle abandons the operation
    start_op(8'h77, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_res",  {24'd0, result}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("abort_nodone", done_cnt, 0);
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, cin_seq);

`ifdef SERADD_SUB_EN
    run_op("sub10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, cin_seq);
    run_op("sub01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, cin_seq);
    run_op("add_after_sub", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, cin_seq);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
